// File: rtl/pr_shell_pkg.sv
// Shared definitions for the partial-reconfiguration shell: isolation FSM state encoding
// and the per-state registered output table.
package pr_shell_pkg;

    typedef enum logic [1:0] {
        StActive    = 2'd0,
        StDrain     = 2'd1,
        StDecoupled = 2'd2,
        StRelease   = 2'd3
    } pr_state_e;

    typedef struct packed {
        logic block_new;
        logic decouple;
        logic user_rst;
        logic decouple_ack;
    } pr_out_t;

    function automatic pr_out_t state_outputs(input pr_state_e st);
        pr_out_t o;
        unique case (st)
            StActive:    o = '{block_new: 1'b0, decouple: 1'b0, user_rst: 1'b0, decouple_ack: 1'b0};
            StDrain:     o = '{block_new: 1'b1, decouple: 1'b0, user_rst: 1'b0, decouple_ack: 1'b0};
            StDecoupled: o = '{block_new: 1'b1, decouple: 1'b1, user_rst: 1'b1, decouple_ack: 1'b1};
            StRelease:   o = '{block_new: 1'b1, decouple: 1'b0, user_rst: 1'b1, decouple_ack: 1'b0};
            default:     o = '{block_new: 1'b1, decouple: 1'b0, user_rst: 1'b1, decouple_ack: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pr_txn_counter.sv
// Up/down saturating outstanding-transaction counter; err pulses on overflow or underflow
// attempts (the count holds in both cases).
module pr_txn_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        err     = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (inc && !dec) begin
                if (count_q == CntMax) err = 1'b1;
                else                   count_d = count_q + 1'b1;
            end else if (dec && !inc) begin
                if (count_q == '0) err = 1'b1;
                else               count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pr_isolation_ctrl.sv
// Isolation controller for a reconfigurable user partition: drains outstanding AXI
// transactions, isolates the boundary, then holds the partition in reset on release.
module pr_isolation_ctrl
    import pr_shell_pkg::*;
#(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned DRAIN_TIMEOUT = 4096,
    parameter int unsigned RST_HOLD      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic decouple_req,
    input  logic aw_fire,
    input  logic ar_fire,
    input  logic b_fire,
    input  logic r_fire,
    input  logic err_clr,
    output logic block_new,
    output logic decouple,
    output logic user_rst,
    output logic decouple_ack,
    output logic drain_timeout,
    output logic protocol_err
);

    // One timer serves both the drain timeout and the reset hold; size it for the larger.
    localparam int unsigned TmrMax = (DRAIN_TIMEOUT > RST_HOLD) ? DRAIN_TIMEOUT : RST_HOLD;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam logic [TmrW-1:0] DrainLast = TmrW'(DRAIN_TIMEOUT - 1);
    localparam logic [TmrW-1:0] HoldLast  = TmrW'(RST_HOLD - 1);

    pr_state_e        state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    pr_out_t          out_q;
    logic             drain_timeout_q, drain_timeout_d;
    logic             protocol_err_q, protocol_err_d;
    logic             timeout_set;

    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic             wr_err, rd_err;
    logic             cnt_en, cnt_clr;

    // Fires only count while the user side is live; isolation wipes anything left over.
    assign cnt_en  = (state_q == StActive) || (state_q == StDrain);
    assign cnt_clr = (state_q == StDecoupled);

    pr_txn_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .inc   (aw_fire),
        .dec   (b_fire),
        .count (wr_cnt),
        .err   (wr_err)
    );

    pr_txn_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .inc   (ar_fire),
        .dec   (r_fire),
        .count (rd_cnt),
        .err   (rd_err)
    );

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q + 1'b1;
        timeout_set = 1'b0;
        unique case (state_q)
            StActive: begin
                tmr_d = '0;
                if (decouple_req) state_d = StDrain;
            end
            StDrain: begin
                // Abort beats both clean completion and timeout.
                if (!decouple_req) begin
                    state_d = StActive;
                    tmr_d   = '0;
                end else if (wr_cnt == '0 && rd_cnt == '0) begin
                    state_d = StDecoupled;
                    tmr_d   = '0;
                end else if (tmr_q == DrainLast) begin
                    state_d     = StDecoupled;
                    tmr_d       = '0;
                    timeout_set = 1'b1;
                end
            end
            StDecoupled: begin
                tmr_d = '0;
                if (!decouple_req) state_d = StRelease;
            end
            StRelease: begin
                if (tmr_q == HoldLast) begin
                    state_d = StActive;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = StRelease;
                tmr_d   = '0;
            end
        endcase
    end

    assign drain_timeout_d = timeout_set || (drain_timeout_q && !err_clr);
    assign protocol_err_d  = wr_err || rd_err || (protocol_err_q && !err_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRelease;
            tmr_q           <= '0;
            out_q           <= state_outputs(StRelease);
            drain_timeout_q <= 1'b0;
            protocol_err_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            tmr_q           <= tmr_d;
            out_q           <= state_outputs(state_d);
            drain_timeout_q <= drain_timeout_d;
            protocol_err_q  <= protocol_err_d;
        end
    end

    assign block_new     = out_q.block_new;
    assign decouple      = out_q.decouple;
    assign user_rst      = out_q.user_rst;
    assign decouple_ack  = out_q.decouple_ack;
    assign drain_timeout = drain_timeout_q;
    assign protocol_err  = protocol_err_q;

endmodule
